// File: rtl/tx_char_queue.sv
// tx_char_queue: byte queue feeding the serial transmitter. It sends one character per SEND state, then holds an idle gap.
// Defining TX_TIMEOUT_EN adds a SEND-state watchdog that drops a stalled character and sets timeoutErr.
module tx_char_queue #(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        wrData,
    input  logic              wrEn,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [7:0]        parallelDataOut,
    output logic              load,
    output logic              transmitEnable,
    input  logic              characterSent,
    output logic              busy,
    output logic              txDone,
    output logic              overflow,
    output logic              timeoutErr
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t            state, stateNext;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr, rdPtr;
    logic [ADDR_W:0]   countNext;
    logic [GAP_W-1:0]  gapCnt, gapCntNext;
    logic              pop, push, sendDone, sendAbort;

`ifdef TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;

    // The timer sits at zero outside SEND, so it restarts on every SEND entry.
    assign sendAbort = (state == SEND) && !characterSent && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            timer <= (state == SEND && stateNext == SEND) ? timer + 1'b1 : '0;
            if (sendAbort)
                timeoutErr <= 1'b1;
        end
    end
`else
    assign sendAbort  = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    // NOTE: every signal assigned in always_comb gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        stateNext  = state;
        gapCntNext = gapCnt;
        pop        = 1'b0;
        sendDone   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (characterSent) begin
                    sendDone   = 1'b1;
                    stateNext  = GAP;
                    gapCntNext = '0;
                end else if (sendAbort) begin
                    stateNext  = GAP;
                    gapCntNext = '0;
                end
            end
            GAP: begin
                if (gapCnt == GAP_W'(GAP_CYCLES - 1))
                    stateNext = IDLE;
                else
                    gapCntNext = gapCnt + 1'b1;
            end
            default: stateNext = IDLE;
        endcase

        // A pop in the same cycle frees a slot, so a full queue can still accept this write.
        push      = wrEn && (!full || pop);
        countNext = count;
        case ({push, pop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            gapCnt          <= '0;
            wrPtr           <= '0;
            rdPtr           <= '0;
            count           <= '0;
            full            <= 1'b0;
            parallelDataOut <= 8'h00;
            load            <= 1'b0;
            transmitEnable  <= 1'b0;
            busy            <= 1'b0;
            txDone          <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            state          <= stateNext;
            gapCnt         <= gapCntNext;
            count          <= countNext;
            full           <= (countNext == (ADDR_W + 1)'(DEPTH));
            load           <= (stateNext == SEND);
            transmitEnable <= (stateNext == SEND);
            busy           <= (stateNext != IDLE);
            txDone         <= sendDone;
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop) begin
                rdPtr           <= rdPtr + 1'b1;
                parallelDataOut <= mem[rdPtr];
            end
            if (wrEn && full && !pop)
                overflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wrPtr] <= wrData;
    end
endmodule

// File: tb/tb_tx_char_queue.sv
// Directed self-checking bench for tx_char_queue with the default parameters (DEPTH 8, GAP_CYCLES 1).
// The watchdog section runs only when TX_TIMEOUT_EN is defined.
module tb_tx_char_queue;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wrData = 8'h00;
    logic       wrEn = 1'b0;
    logic       characterSent = 1'b0;
    logic       full, load, transmitEnable, busy, txDone, overflow, timeoutErr;
    logic [3:0] count;
    logic [7:0] parallelDataOut;

    int nAssert = 0;
    int nFail   = 0;

    tx_char_queue dut (
        .clk             (clk),
        .reset           (reset),
        .wrData          (wrData),
        .wrEn            (wrEn),
        .full            (full),
        .count           (count),
        .parallelDataOut (parallelDataOut),
        .load            (load),
        .transmitEnable  (transmitEnable),
        .characterSent   (characterSent),
        .busy            (busy),
        .txDone          (txDone),
        .overflow        (overflow),
        .timeoutErr      (timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Finish the character in flight and expect the next byte after two low cycles.
    task automatic nextChar(input logic [7:0] exp, input string tag);
        characterSent = 1'b1;
        step();
        check({tag, " txDone"}, txDone, 1);
        check({tag, " te low"}, transmitEnable, 0);
        characterSent = 1'b0;
        step();
        check({tag, " gap te"}, transmitEnable, 0);
        step();
        check({tag, " te"}, {load, transmitEnable}, 2'b11);
        check({tag, " data"}, parallelDataOut, exp);
    endtask

    // Finish the character in flight and expect the queue to go idle afterwards.
    task automatic lastChar(input string tag);
        characterSent = 1'b1;
        step();
        check({tag, " txDone"}, txDone, 1);
        characterSent = 1'b0;
        step();
        check({tag, " txDone off"}, txDone, 0);
        step();
        check({tag, " idle"}, {busy, load, transmitEnable}, 3'b000);
    endtask

    initial begin
        int bad;

        // Reset state, checked while reset is still low.
        #1 reset = 1'b0;
        #3;
        check("reset outputs", {full, load, transmitEnable, busy, txDone, overflow, timeoutErr}, 0);
        check("reset count", count, 0);
        check("reset data", parallelDataOut, 8'h00);
        @(posedge clk);
        #1 reset = 1'b1;

        // One 176-cycle character, then characterSent held into GAP, then a stray pulse in IDLE.
        wrEn = 1'b1; wrData = 8'h55;
        step();
        check("t1 count after write", count, 1);
        check("t1 te before send", transmitEnable, 0);
        wrEn = 1'b0;
        step();
        check("t1 send", {busy, load, transmitEnable}, 3'b111);
        check("t1 data", parallelDataOut, 8'h55);
        check("t1 count after pop", count, 0);
        bad = 0;
        for (int i = 0; i < 175; i++) begin
            step();
            if (!(transmitEnable === 1'b1 && load === 1'b1 && parallelDataOut === 8'h55))
                bad++;
        end
        check("t1 held 176 cycles", bad, 0);
        characterSent = 1'b1;
        step();
        check("t1 txDone", txDone, 1);
        check("t1 te drops", {load, transmitEnable}, 2'b00);
        check("t1 busy in gap", busy, 1);
        step();
        check("t1 sent in gap ignored", txDone, 0);
        check("t1 idle after gap", busy, 0);
        characterSent = 1'b0;
        step();
        check("t1 stays idle", {busy, transmitEnable}, 2'b00);
        characterSent = 1'b1;
        step();
        check("t1 sent in idle ignored", txDone, 0);
        characterSent = 1'b0;
        step();

        // Three bytes back to back; the first pop overlaps the second write.
        wrEn = 1'b1; wrData = 8'h55;
        step();
        check("t2 count e1", count, 1);
        wrData = 8'hAA;
        step();
        check("t2 count e2", count, 1);
        check("t2 first data", parallelDataOut, 8'h55);
        check("t2 first te", transmitEnable, 1);
        wrData = 8'h0F;
        step();
        check("t2 count e3", count, 2);
        wrEn = 1'b0;
        nextChar(8'hAA, "t2 second");
        check("t2 count after second pop", count, 1);
        nextChar(8'h0F, "t2 third");
        check("t2 count after third pop", count, 0);
        lastChar("t2 end");

        // Overflow: one byte in flight, then DEPTH+2 writes.
        wrEn = 1'b1; wrData = 8'hE0;
        step();
        wrEn = 1'b0;
        step();
        check("t3 in flight", parallelDataOut, 8'hE0);
        for (int i = 0; i < 10; i++) begin
            wrEn = 1'b1;
            wrData = 8'h10 + 8'(i);
            step();
            check("t3 count", count, (i < 8) ? i + 1 : 8);
            check("t3 full", full, (i >= 7) ? 1 : 0);
            check("t3 overflow", overflow, (i >= 8) ? 1 : 0);
        end
        wrEn = 1'b0;
        for (int i = 0; i < 8; i++)
            nextChar(8'h10 + 8'(i), "t3 drain");
        lastChar("t3 end");
        check("t3 overflow sticky", overflow, 1);

        // Plain reset clears the sticky overflow flag.
        reset = 1'b0;
        #2;
        check("reset clears overflow", overflow, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Full queue in IDLE: the pop and a write land on the same edge.
        wrEn = 1'b1; wrData = 8'hA0;
        step();
        for (int i = 1; i <= 8; i++) begin
            wrData = 8'hA0 + 8'(i);
            step();
        end
        wrEn = 1'b0;
        check("t4 full", {full, count}, {1'b1, 4'd8});
        check("t4 no overflow", overflow, 0);
        characterSent = 1'b1;
        step();
        check("t4 txDone", txDone, 1);
        characterSent = 1'b0;
        step();
        wrEn = 1'b1; wrData = 8'hBB;
        step();
        wrEn = 1'b0;
        check("t4 count unchanged", count, 8);
        check("t4 still full", full, 1);
        check("t4 write accepted", overflow, 0);
        check("t4 data", parallelDataOut, 8'hA1);
        for (int i = 2; i <= 8; i++)
            nextChar(8'hA0 + 8'(i), "t4 drain");
        nextChar(8'hBB, "t4 last byte");
        lastChar("t4 end");

        // Reset asserted mid-SEND with bytes queued.
        wrEn = 1'b1; wrData = 8'h77;
        step();
        wrData = 8'h78;
        step();
        wrData = 8'h79;
        step();
        wrEn = 1'b0;
        step();
        check("t5 sending", {transmitEnable, count}, {1'b1, 4'd2});
        #2 reset = 1'b0;
        #1;
        check("t5 async drop", {busy, load, transmitEnable}, 3'b000);
        check("t5 count cleared", {full, count}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (transmitEnable !== 1'b0 || busy !== 1'b0 || count !== 4'd0)
                bad++;
        end
        check("t5 quiet after release", bad, 0);
        wrEn = 1'b1; wrData = 8'h5A;
        step();
        wrEn = 1'b0;
        step();
        check("t5 new byte", {transmitEnable, parallelDataOut}, {1'b1, 8'h5A});
        lastChar("t5 end");

`ifdef TX_TIMEOUT_EN
        // Watchdog: characterSent never arrives for the first byte.
        wrEn = 1'b1; wrData = 8'hC1;
        step();
        wrData = 8'hC2;
        step();
        wrEn = 1'b0;
        check("t6 send", {transmitEnable, parallelDataOut}, {1'b1, 8'hC1});
        bad = 0;
        for (int i = 0; i < 254; i++) begin
            step();
            if (transmitEnable !== 1'b1 || timeoutErr !== 1'b0 || txDone !== 1'b0)
                bad++;
        end
        check("t6 held 255 cycles", bad, 0);
        step();
        check("t6 timeoutErr", timeoutErr, 1);
        check("t6 te drops", transmitEnable, 0);
        check("t6 no txDone", txDone, 0);
        step();
        check("t6 no txDone in gap", txDone, 0);
        step();
        check("t6 next byte", {transmitEnable, parallelDataOut}, {1'b1, 8'hC2});
        lastChar("t6 end");
        check("t6 timeoutErr sticky", timeoutErr, 1);
`else
        check("timeoutErr tied low", timeoutErr, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
